// File: rtl/cla_add16_pipe_pkg.sv
// Shared definitions for the two-stage 16-bit carry-lookahead adder:
// word/group geometry, the stage-1 register bundle and a group G/P helper.
package cla_add16_pipe_pkg;

    localparam int GRP_W  = 4;
    localparam int N_GRP  = 4;
    localparam int DATA_W = 16;

    // Everything stage 2 needs to finish the addition.
    typedef struct packed {
        logic [DATA_W-1:0] p;
        logic [DATA_W-1:0] g;
        logic [N_GRP-1:0]  gi;
        logic [N_GRP-1:0]  pi;
        logic              c0;
    } stage1_t;

    // Group generate/propagate of one 4-bit group, returned as {gi, pi}.
    function automatic logic [1:0] grp_gp(input logic [GRP_W-1:0] g,
                                          input logic [GRP_W-1:0] p);
        logic gi_v;
        logic pi_v;
        gi_v = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
               (p[3] & p[2] & p[1] & g[0]);
        pi_v = &p;
        return {gi_v, pi_v};
    endfunction

endpackage

// File: rtl/cla_group4.sv
// One 4-bit lookahead group: group G/P, carry into each bit and the sum bits,
// given the bit generate/propagate terms and the group carry-in.
module cla_group4
    import cla_add16_pipe_pkg::*;
(
    input  logic [GRP_W-1:0] p,
    input  logic [GRP_W-1:0] g,
    input  logic             cin,
    output logic             gi,
    output logic             pi,
    output logic [GRP_W-1:0] c,
    output logic [GRP_W-1:0] s
);

    // Intra-group carries, sums and group lookahead terms.
    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int i = 1; i < GRP_W; i++) begin
            c[i] = g[i-1] | (p[i-1] & c[i-1]);
        end
        s        = p ^ c;
        {gi, pi} = grp_gp(g, p);
    end

endmodule

// File: rtl/cla_add16_pipe.sv
// Two-stage pipelined 16-bit carry-lookahead adder with valid/ready on both
// sides. Stage 1 registers bit and group G/P; stage 2 resolves group carries,
// forms the sum and holds it until the consumer takes it.
// Optional feature: define CLA_SUB_EN to add the sub port (S = A - B).
module cla_add16_pipe
    import cla_add16_pipe_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
`ifdef CLA_SUB_EN
    input  logic              sub,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] s,
    output logic              cout,
    output logic              ovf,
    output logic              gout,
    output logic              pout
);

    logic [DATA_W-1:0] b_eff_s;
    logic              c0_s;
    stage1_t           st1_d_s;
    stage1_t           st1_r;
    logic              v1_r;
    logic              v2_r;
    logic              ld1_s;
    logic              ld2_s;

    logic [N_GRP:0]    grp_c_s;
    logic [DATA_W-1:0] bit_c_s;
    logic [DATA_W-1:0] sum_s;
    logic [N_GRP-1:0]  loc_gi_s;
    logic [N_GRP-1:0]  loc_pi_s;
    logic              gout_s;
    logic              pout_s;
    logic              ovf_s;

    logic [DATA_W-1:0] s_r;
    logic              cout_r;
    logic              ovf_r;
    logic              gout_r;
    logic              pout_r;

    // Operand conditioning: subtraction inverts B and forces carry-in.
`ifdef CLA_SUB_EN
    always_comb begin
        if (sub) begin
            b_eff_s = ~b;
            c0_s    = 1'b1;
        end else begin
            b_eff_s = b;
            c0_s    = cin;
        end
    end
`else
    always_comb begin
        b_eff_s = b;
        c0_s    = cin;
    end
`endif

    // Stage-1 next value: bit terms and first-level group terms.
    always_comb begin
        st1_d_s    = '0;
        st1_d_s.g  = a & b_eff_s;
        st1_d_s.p  = a ^ b_eff_s;
        st1_d_s.c0 = c0_s;
        for (int k = 0; k < N_GRP; k++) begin
            {st1_d_s.gi[k], st1_d_s.pi[k]} =
                grp_gp(st1_d_s.g[k*GRP_W +: GRP_W], st1_d_s.p[k*GRP_W +: GRP_W]);
        end
    end

    // Handshake: stage 2 frees a slot combinationally when the consumer takes.
    always_comb begin
        ld2_s    = v1_r & (~v2_r | out_ready);
        in_ready = ~v1_r | ld2_s;
        ld1_s    = in_valid & in_ready;
    end

    // Stage-1 register and its valid bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_r  <= 1'b0;
            st1_r <= '0;
        end else begin
            v1_r <= ld1_s | (v1_r & ~ld2_s);
            if (ld1_s) begin
                st1_r <= st1_d_s;
            end
        end
    end

    // Second-level lookahead: group carries from registered group G/P.
    always_comb begin
        grp_c_s    = '0;
        grp_c_s[0] = st1_r.c0;
        for (int k = 0; k < N_GRP; k++) begin
            grp_c_s[k+1] = st1_r.gi[k] | (st1_r.pi[k] & grp_c_s[k]);
        end
    end

    for (genvar k = 0; k < N_GRP; k++) begin : g_grp
        cla_group4 u_grp (
            .p   (st1_r.p[k*GRP_W +: GRP_W]),
            .g   (st1_r.g[k*GRP_W +: GRP_W]),
            .cin (grp_c_s[k]),
            .gi  (loc_gi_s[k]),
            .pi  (loc_pi_s[k]),
            .c   (bit_c_s[k*GRP_W +: GRP_W]),
            .s   (sum_s[k*GRP_W +: GRP_W])
        );
    end

    // Whole-word cascade terms and overflow for the stage-2 register.
    always_comb begin
        gout_s = loc_gi_s[3] | (loc_pi_s[3] & loc_gi_s[2]) |
                 (loc_pi_s[3] & loc_pi_s[2] & loc_gi_s[1]) |
                 (loc_pi_s[3] & loc_pi_s[2] & loc_pi_s[1] & loc_gi_s[0]);
        pout_s = &loc_pi_s;
        ovf_s  = bit_c_s[DATA_W-1] ^ grp_c_s[N_GRP];
    end

    // Stage-2 result register; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            v2_r   <= 1'b0;
            s_r    <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            gout_r <= 1'b0;
            pout_r <= 1'b0;
        end else begin
            v2_r <= ld2_s | (v2_r & ~out_ready);
            if (ld2_s) begin
                s_r    <= sum_s;
                cout_r <= grp_c_s[N_GRP];
                ovf_r  <= ovf_s;
                gout_r <= gout_s;
                pout_r <= pout_s;
            end
        end
    end

    assign out_valid = v2_r;
    assign s         = s_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;
    assign gout      = gout_r;
    assign pout      = pout_r;

endmodule

// File: tb/tb_cla_add16_pipe.sv
// Self-checking bench for cla_add16_pipe: directed vectors, backpressure,
// mid-stream reset and a randomized stream against a reference model.
module tb_cla_add16_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
`ifdef CLA_SUB_EN
    logic        sub;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    logic        gout;
    logic        pout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cla_add16_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CLA_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .gout      (gout),
        .pout      (pout)
    );

    // Reference: {gout, pout, ovf, cout, s}
    function automatic logic [19:0] model(input logic [15:0] aa, input logic [15:0] bb,
                                          input logic ci, input logic sb);
        logic [15:0] bp;
        logic        c0;
        logic [16:0] sum;
        logic [15:0] low;
        logic [16:0] gsum;
        bp   = sb ? ~bb : bb;
        c0   = sb ? 1'b1 : ci;
        sum  = {1'b0, aa} + {1'b0, bp} + {16'd0, c0};
        low  = {1'b0, aa[14:0]} + {1'b0, bp[14:0]} + {15'd0, c0};
        gsum = {1'b0, aa} + {1'b0, bp};
        return {gsum[16], &(aa ^ bp), low[15] ^ sum[16], sum[16], sum[15:0]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_sub(input logic v);
`ifdef CLA_SUB_EN
        sub = v;
`else
        if (v) $display("note: sub requested in add-only build");
`endif
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = 16'h0000; b = 16'h0000; cin = 1'b0; set_sub(1'b0);
        tick; tick;
        reset = 1'b0;
        #1;
        checks++;
        if ({out_valid, s, cout, ovf, gout, pout} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b s=%h c=%b o=%b g=%b p=%b, want all 0",
                     out_valid, s, cout, ovf, gout, pout);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_add_directed;
        logic [15:0] va [5] = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'hFFFF, 16'h8000};
        logic [15:0] vb [5] = '{16'h0001, 16'h0000, 16'h0001, 16'h0001, 16'h8000};
        logic        vc [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        // {gout, pout, ovf, cout, s}, computed by hand
        logic [19:0] ve [5] = '{{4'b0000, 16'h0100}, {4'b0101, 16'h0000},
                                {4'b0010, 16'h8000}, {4'b1001, 16'h0000},
                                {4'b1011, 16'h0000}};
        for (int i = 0; i < 5; i++) begin
            tick;
            in_valid = 1'b1; a = va[i]; b = vb[i]; cin = vc[i]; out_ready = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL add%0d_in_ready: got %b want 1", i, in_ready);
            end
            tick;
            in_valid = 1'b0;
            tick;
            checks++;
            if (out_valid !== 1'b1 || {gout, pout, ovf, cout, s} !== ve[i]) begin
                errors++;
                $display("FAIL add%0d: got v=%b {g,p,o,c,s}=%h want v=1 %h",
                         i, out_valid, {gout, pout, ovf, cout, s}, ve[i]);
            end
        end
        tick;
    endtask

    task automatic test_backpressure;
        logic [19:0] exp_q[$];
        logic [15:0] ba [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        logic [15:0] bb [5] = '{16'h0001, 16'h0F0F, 16'hFFFF, 16'h1234, 16'hAAAA};
        logic [19:0] first;
        int idx = 0;
        int got = 0;
        out_ready = 1'b0; cin = 1'b0; set_sub(1'b0);
        for (int c = 0; c < 6; c++) begin
            tick;
            in_valid = (idx < 5); a = ba[idx % 5]; b = bb[idx % 5];
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, 1'b0));
                idx++;
            end
        end
        checks++;
        if (idx !== 2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full: accepted %0d in_ready=%b, want 2 and 0", idx, in_ready);
        end
        first = model(16'h1111, 16'h0001, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || {gout, pout, ovf, cout, s} !== first) begin
            errors++;
            $display("FAIL bp_hold: got v=%b %h want v=1 %h",
                     out_valid, {gout, pout, ovf, cout, s}, first);
        end
        for (int c = 0; c < 30 && got < 5; c++) begin
            tick;
            out_ready = 1'b1;
            in_valid = (idx < 5); a = ba[idx % 5]; b = bb[idx % 5];
            #1;
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra: got %h with nothing expected", s);
                end else if ({gout, pout, ovf, cout, s} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL bp_order%0d: got %h want %h",
                             got, {gout, pout, ovf, cout, s}, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, 1'b0));
                idx++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (got !== 5) begin
            errors++;
            $display("FAIL bp_count: got %0d results want 5", got);
        end
        tick; tick;
    endtask

    task automatic test_reset_midstream;
        tick;
        out_ready = 1'b0; in_valid = 1'b1; a = 16'h0101; b = 16'h0202; cin = 1'b0;
        tick;
        a = 16'h0303;
        tick;
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_full: got v=%b in_ready=%b want 1 0", out_valid, in_ready);
        end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || s !== 16'h0000 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid: got v=%b s=%h in_ready=%b want 0 0000 1",
                     out_valid, s, in_ready);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_stale: cycle %0d got out_valid=%b s=%h want 0", c, out_valid, s);
            end
        end
    endtask

`ifdef CLA_SUB_EN
    task automatic test_sub;
        tick;
        in_valid = 1'b1; a = 16'h0005; b = 16'h0007; cin = 1'b0; sub = 1'b1; out_ready = 1'b1;
        tick;
        in_valid = 1'b0; sub = 1'b0;
        tick;
        checks++;
        if (out_valid !== 1'b1 || s !== 16'hFFFE || cout !== 1'b0) begin
            errors++;
            $display("FAIL sub: got v=%b s=%h c=%b want 1 fffe 0", out_valid, s, cout);
        end
        tick;
    endtask
`endif

    task automatic test_back_to_back(input int n);
        logic [19:0] exp_q[$];
        logic [19:0] last_out;
        logic        stalled = 1'b0;
        logic        pending = 1'b0;
        logic        sb = 1'b0;
        int sent = 0;
        int got = 0;
        for (int c = 0; c < n * 5 + 50 && got < n; c++) begin
            tick;
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || {gout, pout, ovf, cout, s} !== last_out) begin
                    errors++;
                    $display("FAIL b2b_hold: got v=%b %h want v=1 %h",
                             out_valid, {gout, pout, ovf, cout, s}, last_out);
                end
            end
            if (!pending && sent < n && $urandom_range(0, 3) != 0) begin
                a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
`ifdef CLA_SUB_EN
                sb = 1'($urandom); sub = sb;
`endif
                pending = 1'b1;
            end
            in_valid  = pending;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            stalled  = out_valid & ~out_ready;
            last_out = {gout, pout, ovf, cout, s};
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra: got %h with nothing expected", s);
                end else begin
                    if ({gout, pout, ovf, cout, s} !== exp_q[0]) begin
                        errors++;
                        $display("FAIL b2b_data%0d: got %h want %h",
                                 got, {gout, pout, ovf, cout, s}, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, sb));
                pending = 1'b0;
                sent++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (got !== n) begin
            errors++;
            $display("FAIL b2b_count: got %0d results want %0d", got, n);
        end
    endtask

    initial begin
        test_reset;
        test_add_directed;
        test_backpressure;
        test_reset_midstream;
`ifdef CLA_SUB_EN
        test_sub;
        test_back_to_back(10000);
`else
        test_back_to_back(2000);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
